// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader_if
//  Description : Wishbone B3 bus bundle between the FIFO burst reader
//                (master) and the frame-buffer memory port (slave).
//                Signal names keep the master-side _o/_i suffixes.
//  Ports       : wb_adr_o  32         byte address
//                wb_dat_o  DATA_SIZE  write data
//                wb_cyc_o  1          bus cycle in progress
//                wb_stb_o  1          beat strobe
//                wb_we_o   1          write enable
//                wb_sel_o  4          byte selects
//                wb_cti_o  3          cycle type (010 incr burst, 111 end)
//                wb_ack_i  1          slave acknowledge
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if #(
    parameter int DATA_SIZE = 32
);
    logic [31:0]          wb_adr_o;
    logic [DATA_SIZE-1:0] wb_dat_o;
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic                 wb_we_o;
    logic [3:0]           wb_sel_o;
    logic [2:0]           wb_cti_o;
    logic                 wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o,
        output wb_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Drains a FIFO in NB_PACK-word bursts and writes the words
//                to a frame buffer through a Wishbone B3 master. Word index
//                wraps every FRAME_WORDS words; the frame base address is
//                re-sampled each time the index is at (or wraps to) zero.
//  Ports       : clk                  clock, rising edge
//                nRST                 asynchronous active-low reset
//                fifo_data            FIFO head word
//                fifo_pack_available  FIFO holds more than NB_PACK words
//                fifo_r_ack           one-cycle pop pulse to FIFO
//                base_addr            frame buffer byte base (word aligned)
//                wb                   Wishbone master bundle
//                frame_done           (FRAME_IRQ_EN only) end-of-frame pulse
//  Options     : define FRAME_IRQ_EN to add the frame_done output.
//  Notes       : READ_LAT must be at least 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_SIZE   = 32,
    parameter int NB_PACK     = 16,
    parameter int FRAME_WORDS = 307200,
    parameter int READ_LAT    = 2
) (
    input  wire logic                 clk,
    input  wire logic                 nRST,
    input  wire logic [DATA_SIZE-1:0] fifo_data,
    input  wire logic                 fifo_pack_available,
    output logic                      fifo_r_ack,
    input  wire logic [31:0]          base_addr,
    fifo_burst_reader_if.master       wb
`ifdef FRAME_IRQ_EN
    ,
    output logic                      frame_done
`endif
);

    localparam int c_BEAT_W = (NB_PACK > 1) ? $clog2(NB_PACK) : 1;
    localparam int c_IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int c_LAT_W  = $clog2(READ_LAT + 1);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(NB_PACK - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(FRAME_WORDS - 1);
    localparam logic [c_LAT_W-1:0]  c_LAST_LAT  = c_LAT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_LAT_W-1:0]    r_lat_cnt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_IDX_W-1:0]    r_word_idx;
    logic [31:0]           r_frame_base;
    logic [DATA_SIZE-1:0]  r_dat;

    logic                  w_start;
    logic                  w_ack_beat;
    logic                  w_wrap;
    logic                  w_last_beat;
    logic                  w_cyc;
    logic                  w_stb;
    logic [3:0]            w_sel;
    logic [2:0]            w_cti;
    logic [31:0]           w_adr;

    assign w_start     = (r_state == ST_IDLE) && fifo_pack_available;
    // Only an ack seen while strobing counts as a beat; stray acks are dropped.
    assign w_ack_beat  = (r_state == ST_STROBE) && wb.wb_ack_i;
    assign w_wrap      = w_ack_beat && (r_word_idx == c_LAST_IDX);
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_adr       = r_frame_base + (32'(r_word_idx) << 2);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_sel       = 4'h0;
        w_cti       = 3'b000;
        fifo_r_ack  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (fifo_pack_available) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cyc = 1'b1;
                w_cti = w_last_beat ? 3'b111 : 3'b010;
                if (r_lat_cnt == c_LAST_LAT) begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                w_sel = 4'hF;
                w_cti = w_last_beat ? 3'b111 : 3'b010;
                if (wb.wb_ack_i) begin
                    fifo_r_ack  = 1'b1;
                    w_state_nxt = w_last_beat ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latency counter, beat counter, word index, frame base
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_lat_cnt    <= '0;
            r_beat       <= '0;
            r_word_idx   <= '0;
            r_frame_base <= 32'h0;
            r_dat        <= '0;
        end else begin
            // Counts only while in WAIT, so every WAIT visit starts from 0.
            if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
                if (r_lat_cnt == c_LAST_LAT) begin
                    r_dat <= fifo_data;
                end
            end else begin
                r_lat_cnt <= '0;
            end

            if (w_start) begin
                r_beat <= '0;
                if (r_word_idx == '0) begin
                    r_frame_base <= base_addr;
                end
            end

            if (w_ack_beat) begin
                r_beat <= r_beat + c_BEAT_W'(1);
                if (w_wrap) begin
                    // Wrap may land mid-burst: the burst continues at the
                    // freshly sampled base address.
                    r_word_idx   <= '0;
                    r_frame_base <= base_addr;
                end else begin
                    r_word_idx <= r_word_idx + c_IDX_W'(1);
                end
            end
        end
    end

`ifdef FRAME_IRQ_EN
    logic r_frame_done;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
        end
    end

    assign frame_done = r_frame_done;
`endif

    assign wb.wb_adr_o = w_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_cyc_o = w_cyc;
    assign wb.wb_stb_o = w_stb;
    assign wb.wb_we_o  = w_stb;
    assign wb.wb_sel_o = w_sel;
    assign wb.wb_cti_o = w_cti;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Directed bench for fifo_burst_reader with a 24-word frame
//                and 16-word bursts, so the second burst wraps mid-burst.
//                FIFO head word is 0xA5000000 + number of pops so far.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] fifo_data = 32'hA500_0000;
    logic        fifo_pack_available = 1'b0;
    logic        fifo_r_ack;
    logic [31:0] base_addr = 32'h0000_1000;
`ifdef FRAME_IRQ_EN
    logic        frame_done;
`endif

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int racks    = 0;
    int fd_count = 0;
    int racks_mark;

    fifo_burst_reader_if #(.DATA_SIZE(32)) wb ();

    fifo_burst_reader #(
        .DATA_SIZE  (32),
        .NB_PACK    (16),
        .FRAME_WORDS(24),
        .READ_LAT   (2)
    ) u_dut (
        .clk                (clk),
        .nRST               (nRST),
        .fifo_data          (fifo_data),
        .fifo_pack_available(fifo_pack_available),
        .fifo_r_ack         (fifo_r_ack),
        .base_addr          (base_addr),
        .wb                 (wb.master)
`ifdef FRAME_IRQ_EN
        ,
        .frame_done         (frame_done)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_r_ack) racks <= racks + 1;
`ifdef FRAME_IRQ_EN
        if (frame_done) fd_count <= fd_count + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r_ack"}, fifo_r_ack, 0);
        chk({tag, "_cyc"},   wb.wb_cyc_o, 0);
        chk({tag, "_stb"},   wb.wb_stb_o, 0);
        chk({tag, "_we"},    wb.wb_we_o, 0);
        chk({tag, "_adr"},   wb.wb_adr_o, 0);
        chk({tag, "_dat"},   wb.wb_dat_o, 0);
        chk({tag, "_sel"},   wb.wb_sel_o, 0);
        chk({tag, "_cti"},   wb.wb_cti_o, 0);
    endtask

    // Waits (bounded) for the strobe; optionally drives stray acks in WAIT.
    task automatic wait_stb(input logic [31:0] exp_adr, input logic stray);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wb.wb_ack_i = 1'b0;
            #1;
            if (wb.wb_stb_o) break;
            if (stray && wb.wb_cyc_o) begin
                wb.wb_ack_i = 1'b1;
                #1;
                chk("wait_stray_r_ack", fifo_r_ack, 0);
                chk("wait_stray_adr", wb.wb_adr_o, exp_adr);
            end
        end
        chk("stb_seen", wb.wb_stb_o, 1);
    endtask

    task automatic beat(input logic [31:0] exp_adr, input logic [2:0] exp_cti,
                        input int delay, input logic stray);
        logic [31:0] exp_dat;
        wait_stb(exp_adr, stray);
        exp_dat = 32'hA500_0000 + 32'(pops);
        for (int d = 0; d < delay; d++) begin
            chk("hold_stb", wb.wb_stb_o, 1);
            chk("hold_r_ack", fifo_r_ack, 0);
            chk("hold_adr", wb.wb_adr_o, exp_adr);
            chk("hold_dat", wb.wb_dat_o, exp_dat);
            @(negedge clk);
            #1;
        end
        wb.wb_ack_i = 1'b1;
        #1;
        chk("beat_r_ack", fifo_r_ack, 1);
        chk("beat_cyc", wb.wb_cyc_o, 1);
        chk("beat_we", wb.wb_we_o, 1);
        chk("beat_sel", wb.wb_sel_o, 4'hF);
        chk("beat_adr", wb.wb_adr_o, exp_adr);
        chk("beat_cti", wb.wb_cti_o, exp_cti);
        chk("beat_dat", wb.wb_dat_o, exp_dat);
        @(posedge clk);
        #1;
        wb.wb_ack_i = 1'b0;
        pops++;
        fifo_data = 32'hA500_0000 + 32'(pops);
    endtask

    initial begin
        wb.wb_ack_i = 1'b1;   // ack held during reset must not leak through
        #1;
        chk_all_zero("reset");
`ifdef FRAME_IRQ_EN
        chk("reset_frame_done", frame_done, 0);
`endif
        repeat (2) @(negedge clk);
        wb.wb_ack_i = 1'b0;
        fifo_pack_available = 1'b1;
        nRST = 1'b1;

        // Burst 1: base 0x1000, immediate acks, pack drops after beat 0,
        // stray acks during WAIT before beat 1.
        racks_mark = racks;
        for (int k = 0; k < 16; k++) begin
            beat(32'h1000 + 32'(4 * k), (k == 15) ? 3'b111 : 3'b010, 0, k == 1);
            if (k == 0) fifo_pack_available = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("b1_cyc_end", wb.wb_cyc_o, 0);
        chk("b1_racks", racks - racks_mark, 16);

        // Stray acks in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb.wb_ack_i = 1'b1;
            #1;
            chk("idle_stray_r_ack", fifo_r_ack, 0);
            chk("idle_stray_cyc", wb.wb_cyc_o, 0);
            chk("idle_stray_adr", wb.wb_adr_o, 32'h1040);
        end
        @(negedge clk);
        wb.wb_ack_i = 1'b0;

        // Burst 2: words 16..23 then wrap to 0..7 at the new base 0x2000.
        fifo_pack_available = 1'b1;
        racks_mark = racks;
        for (int k = 0; k < 16; k++) begin
            beat((k < 8) ? 32'h1040 + 32'(4 * k) : 32'h2000 + 32'(4 * (k - 8)),
                 (k == 15) ? 3'b111 : 3'b010, (k < 3) ? 3 : 0, 1'b0);
            if (k == 0) fifo_pack_available = 1'b0;
            if (k == 2) base_addr = 32'h2000;
`ifdef FRAME_IRQ_EN
            if (k == 7) chk("frame_done_pulse", frame_done, 1);
`endif
        end
        @(negedge clk);
        #1;
        chk("b2_cyc_end", wb.wb_cyc_o, 0);
        chk("b2_racks", racks - racks_mark, 16);
`ifdef FRAME_IRQ_EN
        chk("b2_frame_done_count", 32'(fd_count), 1);
`endif

        // Burst 3: reset while strobing beat 5.
        fifo_pack_available = 1'b1;
        for (int k = 0; k < 5; k++) begin
            beat(32'h2020 + 32'(4 * k), 3'b010, 0, 1'b0);
            if (k == 0) fifo_pack_available = 1'b0;
        end
        wait_stb(32'h2034, 1'b0);
        chk("b3_beat5_adr", wb.wb_adr_o, 32'h2034);
        racks_mark = racks;
        nRST = 1'b0;
        wb.wb_ack_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_racks", racks - racks_mark, 0);
        wb.wb_ack_i = 1'b0;
        base_addr = 32'h3000;
        fifo_pack_available = 1'b1;
        nRST = 1'b1;

        // Burst 4: restarts at the new base with word index 0.
        racks_mark = racks;
        for (int k = 0; k < 16; k++) begin
            beat(32'h3000 + 32'(4 * k), (k == 15) ? 3'b111 : 3'b010, (k == 3) ? 1 : 0, 1'b0);
            if (k == 0) fifo_pack_available = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("b4_cyc_end", wb.wb_cyc_o, 0);
        chk("b4_racks", racks - racks_mark, 16);
`ifdef FRAME_IRQ_EN
        chk("end_frame_done_count", 32'(fd_count), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, FIFO and Wishbone data width.
REQ-002 SHALL have parameter NB_PACK, default 16, words per burst.
REQ-003 SHALL have parameter FRAME_WORDS, default 307200, words per frame (640x480).
REQ-004 SHALL have parameter READ_LAT, default 2, cycles from fifo_r_ack to valid fifo_data.
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port fifo_data  in  DATA_SIZE  FIFO head word.
REQ-008 SHALL have port fifo_pack_available  in  1  FIFO holds more than NB_PACK words.
REQ-009 SHALL have port fifo_r_ack  out  1  one-cycle pop pulse to FIFO.
REQ-010 SHALL have port base_addr  in  32  frame buffer byte base address, word aligned.
REQ-011 SHALL have ports wb_adr_o out 32, wb_dat_o out DATA_SIZE, wb_cyc_o/wb_stb_o/wb_we_o out 1, wb_sel_o out 4, wb_cti_o out 3, wb_ack_i in 1; Wishbone B3 master.

Function
REQ-012 SHALL implement states IDLE, WAIT, STROBE.
REQ-013 IDLE: all bus strobes low; on fifo_pack_available=1 SHALL enter WAIT with beat counter=0 and wb_cyc_o=1.
REQ-014 WAIT: SHALL count READ_LAT cycles, then latch fifo_data into wb_dat_o and enter STROBE.
REQ-015 STROBE: SHALL drive wb_stb_o=1, wb_we_o=1, wb_sel_o=4'hF until wb_ack_i=1.
REQ-016 On wb_ack_i in STROBE, SHALL pulse fifo_r_ack for exactly that cycle and deassert wb_stb_o next cycle.
REQ-017 After ack of beats 0..NB_PACK-2, SHALL return to WAIT; after beat NB_PACK-1, SHALL drop wb_cyc_o and enter IDLE.
REQ-018 wb_cti_o SHALL be 3'b010 on beats 0..NB_PACK-2 and 3'b111 on the last beat.
REQ-019 wb_cyc_o SHALL stay high from first WAIT through last ack; wb_stb_o low in WAIT is permitted.
REQ-020 wb_adr_o SHALL equal frame_base + 4*word_idx; word_idx increments on each ack.
REQ-021 word_idx SHALL wrap from FRAME_WORDS-1 to 0; frame_base SHALL be sampled from base_addr when a burst starts with word_idx=0.
REQ-022 FRAME_WORDS not a multiple of NB_PACK: wrap SHALL occur mid-burst, address jumps to new frame_base without ending the burst.
REQ-023 fifo_pack_available deasserting mid-burst SHALL be ignored; the burst completes all NB_PACK beats.
REQ-024 Exactly NB_PACK fifo_r_ack pulses SHALL be issued per burst, never while wb_ack_i=0.
REQ-025 wb_ack_i outside STROBE SHALL be ignored.

Reset
REQ-026 nRST low SHALL asynchronously force state IDLE, word_idx=0, beat counter=0, frame_base=0.
REQ-027 During reset all outputs SHALL be 0: fifo_r_ack, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o.
REQ-028 Reset mid-burst SHALL abandon the burst with no further fifo_r_ack; after release, the first burst starts at base_addr.

Configuration
REQ-029 Macro FRAME_IRQ_EN defined: SHALL add output frame_done (1 bit, reset 0), pulsed one cycle in the cycle after the ack of word FRAME_WORDS-1.
REQ-030 FRAME_IRQ_EN undefined: port frame_done SHALL be absent; wrap behaviour unchanged.

Verification
REQ-031 Reset, fifo_pack_available=1, base_addr=0x1000, ack every STROBE cycle -> 16 beats at 0x1000..0x103C, cti 010 x15 then 111, 16 r_ack pulses, then cyc=0.
REQ-032 wb_ack_i delayed 3 cycles per beat -> stb held, no r_ack until ack, wb_dat_o stable, addresses unchanged.
REQ-033 FRAME_WORDS=24, NB_PACK=16, base_addr changed to 0x2000 during second burst -> beats 16..23 at 0x1040..0x105C, beats 0..7 at 0x2000..0x201C in the same burst; frame_done pulses once (FRAME_IRQ_EN).
REQ-034 fifo_pack_available dropped after first beat -> all 16 beats still issued.
REQ-035 nRST asserted at beat 5 -> all outputs 0 immediately; after release and pack available, first address = base_addr.
REQ-036 Stray wb_ack_i in IDLE and WAIT -> no r_ack, no state or address change.
